anubis_round_ctrl: RTL and testbench

//  Iterative sequencer for the Anubis 128-bit block datapath. Accepts one block per handshake,

---
 rtl/anubis_pkg.sv | 59 +++++
 rtl/anubis_round.sv | 38 +++
 rtl/anubis_round_ctrl.sv | 103 ++++++++++
 tb/tb_anubis_round_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anubis_pkg.sv
// Shared constants, FSM encodings and byte-level helpers for the Anubis round datapath.
package anubis_pkg;

  localparam int BLOCK_W        = 128;
  localparam int ROUNDS_DEFAULT = 12;
  localparam int RK_ADDR_W      = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_KADD  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // 4-bit involutive mini-boxes; nibble x lives at bits [4x+3:4x].
  localparam logic [63:0] P_TAB = 64'h1287_69AD_CB45_0EF3;
  localparam logic [63:0] Q_TAB = 64'h81B7_D40F_C32A_65E9;

  function automatic logic [3:0] mini_p(input logic [3:0] x);
    return P_TAB[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] mini_q(input logic [3:0] x);
    return Q_TAB[{x, 2'b00} +: 4];
  endfunction

  // Gamma S-box: P|Q, cross the inner 2-bit fields, Q|P, cross again, P|Q.
  // Every layer is an involution and the layering is symmetric, so S(S(x)) = x.
  function automatic logic [7:0] sbox(input logic [7:0] u);
    logic [3:0] a, b, c, d, e, f, g, h;
    a = mini_p(u[7:4]);
    b = mini_q(u[3:0]);
    c = {a[3:2], b[3:2]};
    d = {a[1:0], b[1:0]};
    e = mini_q(c);
    f = mini_p(d);
    g = {e[3:2], f[3:2]};
    h = {e[1:0], f[1:0]};
    return {mini_p(g), mini_q(h)};
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1d : 8'h00);
  endfunction

  // Multiply by entry sel of the theta generator row (01, 02, 04, 06).
  function automatic logic [7:0] gf_mul_h(input logic [7:0] a, input logic [1:0] sel);
    logic [7:0] a2, a4, y;
    a2 = xtime(a);
    a4 = xtime(a2);
    case (sel)
      2'd0:    y = a;
      2'd1:    y = a2;
      2'd2:    y = a4;
      default: y = a4 ^ a2;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/anubis_round.sv
// One combinational Anubis round: gamma -> tau -> theta (skipped on the last round) -> sigma.
// The block is a 4x4 byte matrix, row-major, byte 0 in the most significant position.
module anubis_round
  import anubis_pkg::*;
(
  input  logic [BLOCK_W-1:0] in,
  input  logic [BLOCK_W-1:0] rk,
  input  logic               last,
  output logic [BLOCK_W-1:0] out
);

  logic [7:0] gam_b [16];
  logic [7:0] tau_b [16];
  logic [7:0] the_b [16];

  genvar gi, gj;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_gamma
      assign gam_b[gi] = sbox(in[BLOCK_W-1-8*gi -: 8]);
    end

    for (gi = 0; gi < 4; gi++) begin : g_row
      for (gj = 0; gj < 4; gj++) begin : g_col
        // tau: matrix transpose
        assign tau_b[4*gi+gj] = gam_b[4*gj+gi];
        // theta: row times the circulant-like H, H[k][j] = h[k ^ j]
        assign the_b[4*gi+gj] = gf_mul_h(tau_b[4*gi+0], 2'(gj))
                              ^ gf_mul_h(tau_b[4*gi+1], 2'(gj ^ 1))
                              ^ gf_mul_h(tau_b[4*gi+2], 2'(gj ^ 2))
                              ^ gf_mul_h(tau_b[4*gi+3], 2'(gj ^ 3));
        // sigma: round-key addition
        assign out[BLOCK_W-1-8*(4*gi+gj) -: 8] =
          (last ? tau_b[4*gi+gj] : the_b[4*gi+gj]) ^ rk[BLOCK_W-1-8*(4*gi+gj) -: 8];
      end
    end
  endgenerate

endmodule

// File: rtl/anubis_round_ctrl.sv
// Iterative Anubis sequencer: one block in, key addition plus ROUNDS rounds on a
// shared round datapath, result held on a valid/ready port. ROUNDS must be 2..31.
module anubis_round_ctrl
  import anubis_pkg::*;
#(
  parameter int ROUNDS  = ROUNDS_DEFAULT,
  parameter int BLOCK_W = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BLOCK_W-1:0]   in_block,
  input  logic                 in_decrypt,
  output logic [RK_ADDR_W-1:0] rk_addr,
  output logic                 rk_decrypt,
  input  logic [BLOCK_W-1:0]   rk_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BLOCK_W-1:0]   out_block,
  output logic                 busy
);

  localparam logic [RK_ADDR_W-1:0] R_LAST = RK_ADDR_W'(ROUNDS);

  logic [1:0]           state_reg, state_next;
  logic [RK_ADDR_W-1:0] r_reg, r_next;
  logic [BLOCK_W-1:0]   data_reg, data_next;
  logic                 mode_reg, mode_next;
  logic [BLOCK_W-1:0]   round_out;
  logic [RK_ADDR_W-1:0] r_eff;
  logic                 last;

  assign last = (r_reg == R_LAST);

  anubis_round u_round (
    .in   (data_reg),
    .rk   (rk_data),
    .last (last),
    .out  (round_out)
  );

  // Next-state logic for the FSM, round counter, data and mode registers.
  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    data_next  = data_reg;
    mode_next  = mode_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          data_next  = in_block;
          mode_next  = in_decrypt;
          r_next     = '0;
          state_next = ST_KADD;
        end
      end
      ST_KADD: begin
        data_next  = data_reg ^ rk_data;
        r_next     = RK_ADDR_W'(1);
        state_next = ST_ROUND;
      end
      ST_ROUND: begin
        data_next = round_out;
        if (last) begin
          state_next = ST_DONE;
        end else begin
          r_next = r_reg + 1'b1;
        end
      end
      default: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  // State registers with synchronous reset; a reset mid-operation discards the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      r_reg     <= '0;
      data_reg  <= '0;
      mode_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
      data_reg  <= data_next;
      mode_reg  <= mode_next;
    end
  end

  // Outside ROUND the key store is pointed at idx(0), which KADD consumes.
  assign r_eff      = (state_reg == ST_ROUND) ? r_reg : '0;
  assign rk_addr    = mode_reg ? (R_LAST - r_eff) : r_eff;
  assign rk_decrypt = mode_reg;
  assign in_ready   = (state_reg == ST_IDLE);
  assign busy       = (state_reg == ST_KADD) || (state_reg == ST_ROUND);
  assign out_valid  = (state_reg == ST_DONE);
  assign out_block  = (state_reg == ST_DONE) ? data_reg : '0;

endmodule

// File: tb/tb_anubis_round_ctrl.sv
// Scoreboard bench for anubis_round_ctrl with a byte-matrix reference cipher and key store.
module tb_anubis_round_ctrl;

  localparam int R = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_decrypt;
  logic [127:0] in_block;
  logic [4:0]   rk_addr;
  logic         rk_decrypt;
  logic [127:0] rk_data;
  logic         out_valid, out_ready;
  logic [127:0] out_block;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  logic [127:0] exp_q[$];
  logic [7:0]   sb[256];
  logic [3:0]   pbox[16] = '{4'h3, 4'hF, 4'hE, 4'h0, 4'h5, 4'h4, 4'hB, 4'hC,
                             4'hD, 4'hA, 4'h9, 4'h6, 4'h7, 4'h8, 4'h2, 4'h1};
  logic [3:0]   qbox[16] = '{4'h9, 4'hE, 4'h5, 4'h6, 4'hA, 4'h2, 4'h3, 4'hC,
                             4'hF, 4'h0, 4'h4, 4'hD, 4'h7, 4'hB, 4'h1, 4'h8};
  logic [7:0]   hrow[4]  = '{8'h01, 8'h02, 8'h04, 8'h06};
  logic [127:0] keys[32];
  logic [127:0] dkeys[32];

  anubis_round_ctrl #(.ROUNDS(R), .BLOCK_W(128)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_block   (in_block),
    .in_decrypt (in_decrypt),
    .rk_addr    (rk_addr),
    .rk_decrypt (rk_decrypt),
    .rk_data    (rk_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Golden key store: encryption keys as-is, decryption set holds theta(K) for inner indices.
  assign rk_data = rk_decrypt ? dkeys[rk_addr] : keys[rk_addr];

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endfunction

  function automatic void chkb(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, act, req);
    end
  endfunction

  // Generic GF(2^8) multiply, shift-and-add modulo 0x11d.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] byte_of(input logic [127:0] v, input int i, input int j);
    return v[127-8*(4*i+j) -: 8];
  endfunction

  // theta: state matrix multiplied by H, H[k][j] = hrow[k xor j].
  function automatic logic [127:0] m_theta(input logic [127:0] v);
    logic [127:0] o;
    logic [7:0]   s;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = 8'h00;
        for (int k = 0; k < 4; k++) s = s ^ gmul(byte_of(v, i, k), hrow[k ^ j]);
        o[127-8*(4*i+j) -: 8] = s;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] m_round(input logic [127:0] x, input logic [127:0] k, input bit lst);
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        y[127-8*(4*i+j) -: 8] = sb[byte_of(x, j, i)];
    if (!lst) y = m_theta(y);
    return y ^ k;
  endfunction

  // Full cipher; decryption uses K'0 = K[R], K'r = theta(K[R-r]), K'R = K[0].
  function automatic logic [127:0] m_cipher(input logic [127:0] x, input bit dec);
    logic [127:0] ks[R+1];
    logic [127:0] s;
    for (int r = 0; r <= R; r++) begin
      if (!dec)        ks[r] = keys[r];
      else if (r == 0) ks[r] = keys[R];
      else if (r == R) ks[r] = keys[0];
      else             ks[r] = m_theta(keys[R-r]);
    end
    s = x ^ ks[0];
    for (int r = 1; r <= R; r++) s = m_round(s, ks[r], r == R);
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: compare every completed output handshake against the scoreboard.
  always @(negedge clk) begin
    logic [127:0] e;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h, want no output", out_block);
      end else begin
        e = exp_q.pop_front();
        chk("out_block", out_block, e);
        $display("txn %0d: out_block=%h expected=%h", txn, out_block, e);
        txn++;
      end
    end
  end

  task automatic send(input logic [127:0] blk, input logic dec, input logic [127:0] exp);
    int n;
    n = 0;
    in_block   = blk;
    in_decrypt = dec;
    in_valid   = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=%b, want 1", in_ready);
    end
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: got %0d pending, want 0", exp_q.size());
      exp_q.delete();
    end
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]   v;
    logic [127:0] pt0, ct0, blk, cap;
    logic         dec;
    int           n;

    rst = 1'b1; in_valid = 1'b0; in_block = '0; in_decrypt = 1'b0; out_ready = 1'b1;

    for (int u = 0; u < 256; u++) begin
      v = 8'(u);
      v = {pbox[v[7:4]], qbox[v[3:0]]};
      v = {v[7:6], v[3:2], v[5:4], v[1:0]};
      v = {qbox[v[7:4]], pbox[v[3:0]]};
      v = {v[7:6], v[3:2], v[5:4], v[1:0]};
      v = {pbox[v[7:4]], qbox[v[3:0]]};
      sb[u] = v;
    end
    for (int a = 0; a < 32; a++) begin
      keys[a]  = (a <= R) ? rnd128() : '0;
    end
    for (int a = 0; a < 32; a++) begin
      dkeys[a] = (a == 0 || a >= R) ? keys[a] : m_theta(keys[a]);
    end

    // Reset values
    repeat (3) @(posedge clk); #1;
    chkb("rst_in_ready", in_ready, 1'b1);
    chkb("rst_out_valid", out_valid, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chk("rst_rk_addr", 128'(rk_addr), 128'(0));
    chkb("rst_rk_decrypt", rk_decrypt, 1'b0);
    chk("rst_out_block", out_block, '0);
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Encrypt known block: address sequence, busy, latency
    pt0 = 128'h000102030405060708090a0b0c0d0e0f;
    ct0 = m_cipher(pt0, 1'b0);
    send(pt0, 1'b0, ct0);
    for (int c = 0; c <= R; c++) begin
      chk("enc_rk_addr", 128'(rk_addr), 128'(c));
      chkb("enc_busy", busy, 1'b1);
      chkb("enc_in_ready", in_ready, 1'b0);
      chkb("enc_out_valid_early", out_valid, 1'b0);
      @(posedge clk); #1;
    end
    chkb("enc_out_valid", out_valid, 1'b1);
    chkb("enc_busy_done", busy, 1'b0);
    wait_done(1'b0);

    // Decrypt the ciphertext: reversed addresses, latched mode, original block back
    send(ct0, 1'b1, pt0);
    in_decrypt = 1'b0;
    for (int c = 0; c <= R; c++) begin
      chk("dec_rk_addr", 128'(rk_addr), 128'(R - c));
      chkb("dec_rk_decrypt", rk_decrypt, 1'b1);
      @(posedge clk); #1;
    end
    chkb("dec_out_valid", out_valid, 1'b1);
    wait_done(1'b0);
    chkb("idle_rk_decrypt_held", rk_decrypt, 1'b1);
    chk("idle_rk_addr_dec", 128'(rk_addr), 128'(R));

    // Backpressure in DONE
    out_ready = 1'b0;
    blk = rnd128();
    send(blk, 1'b0, m_cipher(blk, 1'b0));
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chkb("bp_out_valid_reached", out_valid, 1'b1);
    cap = out_block;
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_out_block_stable", out_block, cap);
      chkb("bp_out_valid", out_valid, 1'b1);
      chkb("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chkb("bp_release_in_ready", in_ready, 1'b1);
    chkb("bp_release_out_valid", out_valid, 1'b0);
    chk("bp_queue_empty", 128'(exp_q.size()), 128'(0));

    // Second block offered while busy is ignored
    blk = rnd128();
    send(blk, 1'b0, m_cipher(blk, 1'b0));
    repeat (3) @(posedge clk); #1;
    in_block = rnd128();
    in_decrypt = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(1'b0);
    repeat (5) begin
      @(posedge clk); #1;
      chkb("ignored_out_valid", out_valid, 1'b0);
      chkb("ignored_in_ready", in_ready, 1'b1);
    end

    // Reset in ROUND with r=6 during a decrypt
    blk = rnd128();
    send(blk, 1'b1, m_cipher(blk, 1'b1));
    repeat (6) @(posedge clk); #1;
    chk("mid_rk_addr_r6", 128'(rk_addr), 128'(R - 6));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    chkb("mid_rst_in_ready", in_ready, 1'b1);
    chkb("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_rk_addr", 128'(rk_addr), 128'(0));
    chkb("mid_rst_busy", busy, 1'b0);
    chkb("mid_rst_rk_decrypt", rk_decrypt, 1'b0);
    repeat (R + 4) begin
      @(posedge clk); #1;
      chkb("mid_rst_no_output", out_valid, 1'b0);
    end
    blk = rnd128();
    send(blk, 1'b0, m_cipher(blk, 1'b0));
    wait_done(1'b0);

    // Randomized blocks, modes and output backpressure
    for (int t = 0; t < 20; t++) begin
      blk = rnd128();
      dec = 1'($urandom_range(0, 1));
      send(blk, dec, m_cipher(blk, dec));
      wait_done(1'b1);
    end

    repeat (3) @(posedge clk); #1;
    chk("final_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
